// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-and-add MUL sequencer.
// Contents:
//   - DEFAULT_WORD_BITWIDTH : default operand/product width
//   - alu_op_e              : operation codes understood by the team ALU
//   - seq_state_e           : sequencer state encoding (2 bits)
package alu_mul_sequencer_pkg;

  localparam int DEFAULT_WORD_BITWIDTH = 32;

  typedef enum logic [3:0] {
    ALU_AND       = 4'b0000,
    ALU_OR        = 4'b0001,
    ALU_ADD       = 4'b0010,
    ALU_XOR       = 4'b0011,
    ALU_SLL       = 4'b0100,
    ALU_SRL       = 4'b0101,
    ALU_SUBTRACT  = 4'b0110,
    ALU_LESS_THAN = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer_alu.sv
// Team combinational ALU.
// Ports:
//   op_i     : operation select (alu_op_e)
//   a_i, b_i : operands, WIDTH bits
//   result_o : operation result, WIDTH bits (carries/borrows are dropped)
//   zero_o   : high when result_o is all zeros
module alu_mul_sequencer_alu
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WORD_BITWIDTH
) (
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  localparam int SHAMT_BITWIDTH = $clog2(WIDTH);

  // Operation decode; shifts use only the low log2(WIDTH) bits of b_i.
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_AND:       result_o = a_i & b_i;
      ALU_OR:        result_o = a_i | b_i;
      ALU_ADD:       result_o = a_i + b_i;
      ALU_XOR:       result_o = a_i ^ b_i;
      ALU_SLL:       result_o = a_i << b_i[SHAMT_BITWIDTH-1:0];
      ALU_SRL:       result_o = a_i >> b_i[SHAMT_BITWIDTH-1:0];
      ALU_SUBTRACT:  result_o = a_i - b_i;
      ALU_LESS_THAN: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default:       result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-and-add multiplier (low half of the product) built
// around one team ALU instance that performs one addition per RUN cycle.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   req_valid/req_ready           : operand handshake (req_a multiplicand, req_b multiplier)
//   resp_valid/resp_ready         : product handshake
//   resp_product                  : product mod 2^WORD_BITWIDTH
//   resp_cycles                   : number of RUN cycles the operation took
//   busy                          : high in RUN or DONE (pipeline stall)
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WORD_BITWIDTH = DEFAULT_WORD_BITWIDTH,
  parameter bit EARLY_EXIT    = 1'b1,
  parameter int CNT_BITWIDTH  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WORD_BITWIDTH-1:0] req_a,
  input  logic [WORD_BITWIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WORD_BITWIDTH-1:0] resp_product,
  output logic [CNT_BITWIDTH-1:0]  resp_cycles,
  output logic                     busy
);

  localparam logic [CNT_BITWIDTH-1:0] LAST_COUNT = CNT_BITWIDTH'(WORD_BITWIDTH - 1);
  localparam logic [CNT_BITWIDTH-1:0] CNT_ONE    = CNT_BITWIDTH'(1);

  seq_state_e                state_q, state_d;
  logic [WORD_BITWIDTH-1:0]  acc_q, acc_d;
  logic [WORD_BITWIDTH-1:0]  mcand_q, mcand_d;
  logic [WORD_BITWIDTH-1:0]  mplier_q, mplier_d;
  logic [CNT_BITWIDTH-1:0]   count_q, count_d;
  logic [WORD_BITWIDTH-1:0]  product_q, product_d;
  logic [CNT_BITWIDTH-1:0]   cycles_q, cycles_d;
  logic [WORD_BITWIDTH-1:0]  alu_sum_s;
  logic                      alu_zero_unused_s;
  logic                      run_last_s;

  // The ALU is held on ADD permanently, so its op never changes mid-run.
  alu_mul_sequencer_alu #(
    .WIDTH (WORD_BITWIDTH)
  ) u_alu (
    .op_i     (ALU_ADD),
    .a_i      (acc_q),
    .b_i      (mcand_q),
    .result_o (alu_sum_s),
    .zero_o   (alu_zero_unused_s)
  );

  // Last RUN cycle: all bit positions consumed, or (early exit) nothing left to add.
  assign run_last_s = (count_q == LAST_COUNT) ||
                      (EARLY_EXIT && ((mplier_q >> 1) == '0));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a response handoff always passes through IDLE before a new accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = req_valid  ? ST_RUN  : ST_IDLE;
      ST_RUN:  state_d = run_last_s ? ST_DONE : ST_RUN;
      ST_DONE: state_d = resp_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    resp_valid = (state_q == ST_DONE);
  end

  assign resp_product = product_q;
  assign resp_cycles  = cycles_q;

  // Datapath next-state: load on accept, one shift/add step per RUN cycle.
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
    cycles_d  = cycles_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          acc_d    = '0;
          mcand_d  = req_a;
          mplier_d = req_b;
          count_d  = '0;
        end else begin
          acc_d    = acc_q;
        end
      end
      ST_RUN: begin
        acc_d    = mplier_q[0] ? alu_sum_s : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_ONE;
        // Capture includes this cycle's add, so the result is ready on DONE entry.
        if (run_last_s) begin
          product_d = acc_d;
          cycles_d  = count_d;
        end else begin
          product_d = product_q;
        end
      end
      ST_DONE: begin
        acc_d = acc_q;
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
      cycles_q  <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
      cycles_q  <= cycles_d;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench: lane 0 runs EARLY_EXIT=1, lane 1 runs EARLY_EXIT=0.
// Stimulus pushes hand-computed expectations; a per-lane monitor pops and
// compares on each response handshake.
module tb_alu_mul_sequencer;

  typedef struct {
    int          lane;
    logic [31:0] p;
    logic [5:0]  c;
    int unsigned lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic [31:0] req_a        [2];
  logic [31:0] req_b        [2];
  logic        resp_valid   [2];
  logic        resp_ready   [2];
  logic [31:0] resp_product [2];
  logic [5:0]  resp_cycles  [2];
  logic        busy         [2];

  exp_t        sb_q[$];
  int unsigned cyc;
  int          n_pass;
  int          n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    alu_mul_sequencer #(
      .WORD_BITWIDTH (32),
      .EARLY_EXIT    (g == 0),
      .CNT_BITWIDTH  (6)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_a        (req_a[g]),
      .req_b        (req_b[g]),
      .resp_valid   (resp_valid[g]),
      .resp_ready   (resp_ready[g]),
      .resp_product (resp_product[g]),
      .resp_cycles  (resp_cycles[g]),
      .busy         (busy[g])
    );

    logic        prev_v;
    int unsigned acc_cyc;
    int unsigned val_cyc;
    logic [31:0] held_p;
    logic [5:0]  held_c;

    // Monitor: latency, hold-while-stalled, and scoreboard compare on handshake.
    always @(negedge clk) begin
      int unsigned vc;
      exp_t e;
      if (rst) begin
        prev_v <= 1'b0;
      end else begin
        if (req_valid[g] && req_ready[g]) acc_cyc <= cyc;
        vc = (resp_valid[g] && !prev_v) ? cyc : val_cyc;
        if (resp_valid[g] && !prev_v) begin
          val_cyc <= cyc;
          held_p  <= resp_product[g];
          held_c  <= resp_cycles[g];
        end else if (resp_valid[g]) begin
          check("hold_product", resp_product[g], held_p);
          check("hold_cycles", resp_cycles[g], held_c);
          check("hold_req_ready", req_ready[g], 1'b0);
        end
        if (resp_valid[g] && resp_ready[g]) begin
          if (sb_q.size() == 0) begin
            check("unexpected_resp", 1'b1, 1'b0);
          end else begin
            e = sb_q.pop_front();
            check("resp_lane", g, e.lane);
            check("resp_product", resp_product[g], e.p);
            check("resp_cycles", resp_cycles[g], e.c);
            check("resp_latency", vc - acc_cyc, e.lat);
          end
        end
        prev_v <= resp_valid[g];
      end
    end
  end

  task automatic push_exp(input int lane, input logic [31:0] p, input logic [5:0] c,
                          input int unsigned lat);
    exp_t e;
    e.lane = lane; e.p = p; e.c = c; e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Drive a request and hold it until accepted; called just after a posedge.
  task automatic issue(input int lane, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [5:0] c, input int unsigned lat);
    bit acc;
    acc = 1'b0;
    push_exp(lane, p, c, lat);
    req_a[lane] = a;
    req_b[lane] = b;
    req_valid[lane] = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (req_ready[lane]) acc = 1'b1;
    end
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    req_valid[lane] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input int lane);
    check("rst_req_ready", req_ready[lane], 1'b1);
    check("rst_busy", busy[lane], 1'b0);
    check("rst_resp_valid", resp_valid[lane], 1'b0);
    check("rst_product", resp_product[lane], 32'h0);
    check("rst_cycles", resp_cycles[lane], 6'd0);
  endtask

  initial begin
    int unsigned hs;
    int unsigned ac;
    bit seen;
    cyc = 0; n_pass = 0; n_total = 0;
    rst = 1'b1;
    for (int l = 0; l < 2; l++) begin
      req_valid[l] = 1'b0; req_a[l] = 32'h0; req_b[l] = 32'h0; resp_ready[l] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Early-exit lane: directed vectors.
    issue(0, 32'd3, 32'd5, 32'd15, 6'd3, 4);                          drain();
    issue(0, 32'd7, 32'd0, 32'd0, 6'd1, 2);                           drain();
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 6'd32, 33); drain();
    issue(0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 6'd1, 2);           drain();

    // Backpressure with a second request held during the stall.
    resp_ready[0] = 1'b0;
    issue(0, 32'd6, 32'd7, 32'd42, 6'd3, 4);
    push_exp(0, 32'h0001_0000, 6'd17, 18);
    req_a[0] = 32'h0001_0000;
    req_b[0] = 32'h0001_0001;
    req_valid[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid[0]) seen = 1'b1;
    end
    check("bp_resp_seen", seen, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_handshake", resp_valid[0], 1'b1);
    hs = cyc;
    seen = 1'b0;
    ac = hs;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (req_ready[0]) begin seen = 1'b1; ac = cyc; end
    end
    check("reaccept_gap", ac - hs, 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    drain();

    // Asynchronous reset during RUN cycle 10 of a full-length operation.
    issue(0, 32'h1234_5678, 32'h8000_0000, 32'h0, 6'd32, 33);
    repeat (9) @(posedge clk);
    #2;
    check("pre_rst_busy", busy[0], 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outputs(0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(0, 32'd6, 32'd7, 32'd42, 6'd3, 4);                          drain();

    // Fixed-length lane.
    issue(1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 6'd32, 33);         drain();
    issue(1, 32'd3, 32'd5, 32'd15, 6'd32, 33);                        drain();
    issue(1, 32'd7, 32'd0, 32'd0, 6'd32, 33);                         drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
